debug_run_controller: RTL and testbench

//  Sequences the MIPS pipeline for the UART debug path: gates the global pipeline `enable`
//  (continuous run, single step, halt) from command bytes received over UART.

---
 rtl/debug_run_controller_pkg.sv | 35 +++
 rtl/debug_run_controller_serializer.sv | 93 +++++++++
 rtl/debug_run_controller.sv | 126 ++++++++++++
 tb/tb_debug_run_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_run_controller_pkg.sv
// Shared definitions for the UART debug run controller: command bytes,
// FSM state encoding and dump geometry.
// Optional feature macro: DBG_CYCLE_COUNT_EN (appends an enabled-cycle
// counter word to every state dump).
package debug_run_controller_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
    localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

    localparam int NREGS = 32;

`ifdef DBG_CYCLE_COUNT_EN
    // PC, 32 GPRs, enabled-cycle counter
    localparam int DUMP_WORDS = NREGS + 2;
`else
    // PC, 32 GPRs
    localparam int DUMP_WORDS = NREGS + 1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_DUMP_LOAD = 3'd3,
        ST_DUMP_SEND = 3'd4,
        ST_DUMP_WAIT = 3'd5
    } state_t;

    function automatic logic is_dump_state(input state_t s);
        return (s == ST_DUMP_LOAD) || (s == ST_DUMP_SEND) || (s == ST_DUMP_WAIT);
    endfunction

endpackage

// File: rtl/debug_run_controller_serializer.sv
// Dump datapath: word selection/latch, MSB-first byte shifter and the UART
// transmit handshake. Sequencing follows the top FSM state it is given.
//
// Handshake: tx_start is a registered one-cycle strobe raised only while
// tx_busy is low; tx_busy is expected to rise the cycle after the strobe,
// so the first DUMP_WAIT cycle (the strobe cycle) is skipped before
// waiting for tx_busy to fall.
//
// Optional feature macro: DBG_CYCLE_COUNT_EN (adds the cycle_count port).
module debug_run_controller_serializer
    import debug_run_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  state_t      state,
    input  logic [31:0] pc_value,
    input  logic [31:0] reg_data,
`ifdef DBG_CYCLE_COUNT_EN
    input  logic [31:0] cycle_count,
`endif
    input  logic        tx_busy,
    output logic [4:0]  reg_sel,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        byte_done,
    output logic        byte_last,
    output logic        word_last
);

    logic [5:0]  word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] shift_q;
    logic [31:0] load_word;
    logic [5:0]  sel_full;

    // Word source: 0 is the PC, k is GPR[k-1], optional trailing counter
    always_comb begin
        sel_full  = word_idx - 6'd1;
        reg_sel   = (word_idx == 6'd0) ? 5'd0 : sel_full[4:0];
        load_word = reg_data;
        if (word_idx == 6'd0) begin
            load_word = pc_value;
        end
`ifdef DBG_CYCLE_COUNT_EN
        else if (word_idx == 6'(NREGS + 1)) begin
            load_word = cycle_count;
        end
`endif
    end

    // A byte completes once the strobe cycle is past and the UART is idle
    assign byte_done = (state == ST_DUMP_WAIT) && !tx_start && !tx_busy;
    assign byte_last = (byte_idx == 2'd3);
    assign word_last = (word_idx == 6'(DUMP_WORDS - 1));

    // Latch, transmit and shift bytes; indices restart outside a dump
    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx <= 6'd0;
            byte_idx <= 2'd0;
            shift_q  <= 32'd0;
            tx_data  <= 8'd0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_DUMP_LOAD: begin
                    shift_q <= load_word;
                end
                ST_DUMP_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= shift_q[31:24];
                    end
                end
                ST_DUMP_WAIT: begin
                    if (byte_done) begin
                        shift_q  <= {shift_q[23:0], 8'h00};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_last) begin
                            word_idx <= word_idx + 6'd1;
                        end
                    end
                end
                default: begin
                    word_idx <= 6'd0;
                    byte_idx <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debug_run_controller.sv
// UART debug run controller: decodes command bytes into pipeline enable
// gating (run / single step / halt) and streams a PC + GPR state dump
// after every stop. fsm_state exposes the controller state for debug.
// Optional feature macro: DBG_CYCLE_COUNT_EN (enabled-cycle counter
// appended as the final dump word).
module debug_run_controller
    import debug_run_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic        halt_detected,
    input  logic [31:0] pc_value,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        enable,
    output logic        dumping,
    output logic [2:0]  fsm_state
);

    state_t state;
    state_t state_next;
    logic   byte_done;
    logic   byte_last;
    logic   word_last;

    assign dumping   = is_dump_state(state);
    assign fsm_state = state;

`ifdef DBG_CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    // Count every cycle the pipeline advances; wraps, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 32'd0;
        end else if (enable) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

    // Command decode and dump sequencing; bytes outside IDLE are dropped
    // except HALT while running
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_RUN) begin
                        state_next = ST_RUN;
                    end else if (rx_data == CMD_STEP) begin
                        state_next = ST_STEP;
                    end else if (rx_data == CMD_DUMP) begin
                        state_next = ST_DUMP_LOAD;
                    end
                end
            end
            ST_RUN: begin
                if ((rx_valid && (rx_data == CMD_HALT)) || halt_detected) begin
                    state_next = ST_DUMP_LOAD;
                end
            end
            ST_STEP: begin
                state_next = ST_DUMP_LOAD;
            end
            ST_DUMP_LOAD: begin
                state_next = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: begin
                if (!tx_busy) begin
                    state_next = ST_DUMP_WAIT;
                end
            end
            ST_DUMP_WAIT: begin
                if (byte_done) begin
                    if (!byte_last) begin
                        state_next = ST_DUMP_SEND;
                    end else if (word_last) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DUMP_LOAD;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; enable is registered from the state being entered so
    // it rises the cycle after a command and drops the cycle after a stop
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            enable <= 1'b0;
        end else begin
            state  <= state_next;
            enable <= (state_next == ST_RUN) || (state_next == ST_STEP);
        end
    end

    debug_run_controller_serializer u_serializer (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .pc_value    (pc_value),
        .reg_data    (reg_data),
`ifdef DBG_CYCLE_COUNT_EN
        .cycle_count (cycle_count),
`endif
        .tx_busy     (tx_busy),
        .reg_sel     (reg_sel),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .byte_done   (byte_done),
        .byte_last   (byte_last),
        .word_last   (word_last)
    );

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed testbench for debug_run_controller: UART tx model, register
// file model, captured byte stream compared against a bench-built dump.
module tb_debug_run_controller;

    localparam logic [7:0] C_RUN  = 8'h63;
    localparam logic [7:0] C_STEP = 8'h73;
    localparam logic [7:0] C_HALT = 8'h68;
    localparam logic [7:0] C_DUMP = 8'h64;
    localparam logic [31:0] PC_VAL = 32'h0040_1A2C;
`ifdef DBG_CYCLE_COUNT_EN
    localparam int NBYTES = 136;
`else
    localparam int NBYTES = 132;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        halt_detected;
    logic [31:0] pc_value;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        enable;
    logic        dumping;
    logic [2:0]  fsm_state;

    logic [31:0] gpr [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          busy_cnt;
    logic        hold_busy;
    int          en_cnt;
    int          errors;
    int          checks;
    int          base;
    int          n;

    debug_run_controller dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .halt_detected (halt_detected),
        .pc_value      (pc_value),
        .reg_sel       (reg_sel),
        .reg_data      (reg_data),
        .enable        (enable),
        .dumping       (dumping),
        .fsm_state     (fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    assign reg_data = gpr[reg_sel];
    assign pc_value = PC_VAL;
    assign tx_busy  = (busy_cnt != 0) || hold_busy;

    // UART tx model and byte capture, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else if (tx_start) begin
            got_q.push_back(tx_data);
            busy_cnt = 3;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
        end
        if (enable) en_cnt = en_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_dump(input string tag, input int budget);
        int k;
        k = 0;
        while (dumping && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, dumping}, 32'd0);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (got_q.size() < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, got_q.size() >= target}, 32'd1);
    endtask

    // scoreboard: build expected PC + GPR byte stream and compare
    task automatic check_dump(input string tag);
        logic [31:0] w;
        int bad;
        exp_q.delete();
        for (int i = 0; i < 33; i++) begin
            w = (i == 0) ? PC_VAL : gpr[i-1];
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        chk({tag, "_len"}, got_q.size(), NBYTES);
        bad = 0;
        for (int i = 0; i < 132; i++) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        end
        chk({tag, "_bad_bytes"}, bad, 0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        en_cnt        = 0;
        busy_cnt      = 0;
        hold_busy     = 1'b0;
        reset         = 1'b1;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        halt_detected = 1'b0;
        for (int i = 0; i < 32; i++) gpr[i] = {8'hA0 + 8'(i), 8'h11 * 8'(i & 7), 8'(i), 8'h5A ^ 8'(i)};

        // reset state
        repeat (3) tick();
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_reg_sel", {27'd0, reg_sel}, 32'd0);
        chk("rst_dumping", {31'd0, dumping}, 32'd0);
        chk("rst_state", {29'd0, fsm_state}, 32'd0);
        reset = 1'b0;
        tick();

        // ignored bytes in IDLE
        got_q.delete();
        send_byte(C_HALT);
        send_byte(8'h41);
        repeat (5) tick();
        chk("idle_ignore_dumping", {31'd0, dumping}, 32'd0);
        chk("idle_ignore_enable", {31'd0, enable}, 32'd0);
        chk("idle_ignore_tx", got_q.size(), 0);

        // single step: one enabled cycle then a full dump
        got_q.delete();
        en_cnt = 0;
        send_byte(C_STEP);
        chk("step_enable_on", {31'd0, enable}, 32'd1);
        tick();
        chk("step_enable_off", {31'd0, enable}, 32'd0);
        chk("step_dumping", {31'd0, dumping}, 32'd1);
        wait_dump("step_done", 3000);
        check_dump("step");
        chk("step_pc_word", {got_q[0], got_q[1], got_q[2], got_q[3]}, PC_VAL);
        chk("step_enable_cycles", en_cnt, 1);

        // run, then halt_detected 20 cycles later
        got_q.delete();
        send_byte(C_RUN);
        chk("run_enable", {31'd0, enable}, 32'd1);
        repeat (19) tick();
        chk("run_enable_still", {31'd0, enable}, 32'd1);
        chk("run_not_dumping", {31'd0, dumping}, 32'd0);
        halt_detected = 1'b1;
        tick();
        halt_detected = 1'b0;
        chk("halt_enable_off", {31'd0, enable}, 32'd0);
        chk("halt_dumping", {31'd0, dumping}, 32'd1);
        wait_dump("halt_done", 3000);
        check_dump("halt");

        // run, then 'h' and halt_detected together; a 'c' mid-dump is dropped
        got_q.delete();
        send_byte(C_RUN);
        repeat (5) tick();
        rx_data       = C_HALT;
        rx_valid      = 1'b1;
        halt_detected = 1'b1;
        tick();
        rx_valid      = 1'b0;
        halt_detected = 1'b0;
        chk("both_enable_off", {31'd0, enable}, 32'd0);
        chk("both_dumping", {31'd0, dumping}, 32'd1);
        repeat (20) tick();
        send_byte(C_RUN);
        wait_dump("both_done", 3000);
        repeat (40) tick();
        check_dump("both");
        chk("drop_run_enable", {31'd0, enable}, 32'd0);
        chk("drop_run_dumping", {31'd0, dumping}, 32'd0);

        // dump-only with a known GPR pattern
        gpr[5] = 32'hDEADBEEF;
        got_q.delete();
        en_cnt = 0;
        send_byte(C_DUMP);
        chk("dump_dumping", {31'd0, dumping}, 32'd1);
        wait_dump("dump_done", 3000);
        check_dump("dump");
        chk("dump_gpr5", {got_q[24], got_q[25], got_q[26], got_q[27]}, 32'hDEADBEEF);
        chk("dump_no_enable", en_cnt, 0);

        // tx_busy held high mid-dump, then reset at byte 60
        got_q.delete();
        send_byte(C_DUMP);
        wait_bytes("busy_reach10", 10, 500);
        hold_busy = 1'b1;
        tick();
        base = got_q.size();
        repeat (50) tick();
        chk("busy_no_tx", got_q.size(), base);
        chk("busy_still_dumping", {31'd0, dumping}, 32'd1);
        hold_busy = 1'b0;
        wait_bytes("busy_reach60", 60, 2000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_dumping", {31'd0, dumping}, 32'd0);
        chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("midrst_state", {29'd0, fsm_state}, 32'd0);
        base = got_q.size();
        repeat (100) tick();
        chk("midrst_no_more_tx", got_q.size(), base);

        // three steps from reset; third dump carries the counter when enabled
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            got_q.delete();
            send_byte(C_STEP);
            tick();
            wait_dump("step3_done", 3000);
        end
        check_dump("step3");
`ifdef DBG_CYCLE_COUNT_EN
        chk("step3_counter", {got_q[132], got_q[133], got_q[134], got_q[135]}, 32'h00000003);
`endif
        n = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
